// File: rtl/cursor_stepper.sv
// Purpose: etch-a-sketch cursor/pen controller; moves one pixel per step, emits ink writes, sweeps screen on clear.
// Latency: step or clear edge in IDLE -> registered write request one cycle later; all outputs are registered.
// Backpressure: wr_valid/payload hold until wr_ready; steps arriving while a write is pending are dropped.
module cursor_stepper #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320,
   parameter int CW     = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic [3:0]    buttons,
   input  logic          clear,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          busy,
   output logic          wr_valid,
   input  logic          wr_ready,
   output logic [CW-1:0] wr_x,
   output logic [CW-1:0] wr_y,
   output logic          wr_color
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLOT  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   // Reset position is the screen centre; edges are the last valid coordinate.
   localparam logic [CW-1:0] X_RST = CW'(WIDTH / 2);
   localparam logic [CW-1:0] Y_RST = CW'(HEIGHT / 2);
   localparam logic [CW-1:0] X_MAX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] Y_MAX = CW'(HEIGHT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] x_nxt, y_nxt;
   logic [CW-1:0] wr_x_nxt, wr_y_nxt;
   logic          wr_valid_nxt, wr_color_nxt, busy_nxt;
   logic          clear_q;
   logic          clr_pend, clr_pend_nxt;
   logic [CW-1:0] sx, sy, sx_nxt, sy_nxt;

   logic          btn_up, btn_down, btn_left, btn_right;
   logic          clr_edge;
   logic [CW-1:0] mx, my;
   logic          moved;
   logic          hs;
   logic          sx_last, sy_last;

   assign btn_up    = buttons[3];
   assign btn_down  = buttons[2];
   assign btn_left  = buttons[1];
   assign btn_right = buttons[0];

   // Only the rising edge of the clear level starts a sweep.
   assign clr_edge = clear & ~clear_q;
   assign hs       = wr_valid & wr_ready;
   assign sx_last  = (sx == X_MAX);
   assign sy_last  = (sy == Y_MAX);

   // Candidate position for this step: opposing buttons cancel, edges saturate.
   always_comb begin
      mx = x;
      my = y;
      if (btn_right && !btn_left && (x != X_MAX)) begin
         mx = x + CW'(1);
      end else if (btn_left && !btn_right && (x != '0)) begin
         mx = x - CW'(1);
      end
      if (btn_down && !btn_up && (y != Y_MAX)) begin
         my = y + CW'(1);
      end else if (btn_up && !btn_down && (y != '0)) begin
         my = y - CW'(1);
      end
   end

   assign moved = (mx != x) || (my != y);

   // Next-state and registered-output logic; every register holds unless a branch says otherwise.
   always_comb begin
      state_nxt    = state;
      x_nxt        = x;
      y_nxt        = y;
      wr_x_nxt     = wr_x;
      wr_y_nxt     = wr_y;
      wr_valid_nxt = wr_valid;
      wr_color_nxt = wr_color;
      busy_nxt     = busy;
      clr_pend_nxt = clr_pend;
      sx_nxt       = sx;
      sy_nxt       = sy;

      unique case (state)
         IDLE: begin
            if (clr_edge || clr_pend) begin
               // Clear beats a coincident step; the step is simply lost.
               state_nxt    = CLEAR;
               clr_pend_nxt = 1'b0;
               busy_nxt     = 1'b1;
               sx_nxt       = '0;
               sy_nxt       = '0;
               wr_x_nxt     = '0;
               wr_y_nxt     = '0;
               wr_color_nxt = 1'b0;
               wr_valid_nxt = 1'b1;
            end else if (step && moved) begin
               state_nxt    = PLOT;
               x_nxt        = mx;
               y_nxt        = my;
               wr_x_nxt     = mx;
               wr_y_nxt     = my;
               wr_color_nxt = 1'b1;
               wr_valid_nxt = 1'b1;
            end
         end

         PLOT: begin
            // Remember a clear that arrives while the ink write is outstanding.
            if (clr_edge) begin
               clr_pend_nxt = 1'b1;
            end
            if (hs) begin
               wr_valid_nxt = 1'b0;
               state_nxt    = IDLE;
            end
         end

         CLEAR: begin
            if (hs) begin
               if (sx_last && sy_last) begin
                  // Sweep done: redraw the cursor pixel over the fresh background.
                  busy_nxt     = 1'b0;
                  wr_x_nxt     = x;
                  wr_y_nxt     = y;
                  wr_color_nxt = 1'b1;
                  state_nxt    = PLOT;
               end else if (sx_last) begin
                  sx_nxt   = '0;
                  sy_nxt   = sy + CW'(1);
                  wr_x_nxt = '0;
                  wr_y_nxt = sy + CW'(1);
               end else begin
                  sx_nxt   = sx + CW'(1);
                  wr_x_nxt = sx + CW'(1);
               end
            end
         end

         default: begin
            state_nxt    = IDLE;
            wr_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any write or sweep in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         x        <= X_RST;
         y        <= Y_RST;
         wr_x     <= '0;
         wr_y     <= '0;
         wr_valid <= 1'b0;
         wr_color <= 1'b0;
         busy     <= 1'b0;
         clear_q  <= 1'b0;
         clr_pend <= 1'b0;
         sx       <= '0;
         sy       <= '0;
      end else begin
         state    <= state_nxt;
         x        <= x_nxt;
         y        <= y_nxt;
         wr_x     <= wr_x_nxt;
         wr_y     <= wr_y_nxt;
         wr_valid <= wr_valid_nxt;
         wr_color <= wr_color_nxt;
         busy     <= busy_nxt;
         clear_q  <= clear;
         clr_pend <= clr_pend_nxt;
         sx       <= sx_nxt;
         sy       <= sy_nxt;
      end
   end

endmodule

// File: tb/tb_cursor_stepper.sv
// Purpose: self-checking bench for cursor_stepper; full-size instance for moves, small 4x3 instance for clear sweeps.
// Latency: inputs driven on the falling edge, outputs compared on the following falling edge.
// Backpressure: wr_ready is driven per vector to exercise payload hold and dropped steps.
module tb_cursor_stepper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Full-size instance (240x320)
   logic       rst_m, step_m, clear_m, rdy_m;
   logic [3:0] btn_m;
   logic [8:0] x_m, y_m, wx_m, wy_m;
   logic       busy_m, v_m, c_m;

   cursor_stepper #(.WIDTH(240), .HEIGHT(320), .CW(9)) dut (
      .clk(clk), .rst(rst_m), .step(step_m), .buttons(btn_m), .clear(clear_m),
      .x(x_m), .y(y_m), .busy(busy_m), .wr_valid(v_m), .wr_ready(rdy_m),
      .wr_x(wx_m), .wr_y(wy_m), .wr_color(c_m)
   );

   // Small instance (4x3) for sweep tests
   logic       rst_s, step_s, clear_s, rdy_s;
   logic [3:0] btn_s;
   logic [2:0] x_s, y_s, wx_s, wy_s;
   logic       busy_s, v_s, c_s;

   cursor_stepper #(.WIDTH(4), .HEIGHT(3), .CW(3)) dut_s (
      .clk(clk), .rst(rst_s), .step(step_s), .buttons(btn_s), .clear(clear_s),
      .x(x_s), .y(y_s), .busy(busy_s), .wr_valid(v_s), .wr_ready(rdy_s),
      .wr_x(wx_s), .wr_y(wy_s), .wr_color(c_s)
   );

   // Accepted-write counter on the full-size instance
   int hs_cnt = 0;
   always @(posedge clk) begin
      if (rst_m && v_m && rdy_m) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic       stp;
      logic [3:0] btn;
      logic       rdy;
      int         ex, ey;
      int         ev;
      int         ewx, ewy, ec;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic stp, input logic [3:0] btn, input logic rdy,
                               input int ex, input int ey, input int ev,
                               input int ewx, input int ewy, input int ec);
      vec_t v;
      v.stp = stp; v.btn = btn; v.rdy = rdy;
      v.ex = ex; v.ey = ey; v.ev = ev;
      v.ewx = ewx; v.ewy = ewy; v.ec = ec;
      return v;
   endfunction

   task automatic drive_s(input logic st, input logic [3:0] b, input logic r, input logic c);
      step_s  = st;
      btn_s   = b;
      rdy_s   = r;
      clear_s = c;
      @(negedge clk);
   endtask

   task automatic chk_s(input string tag, input int ex, input int ey, input int ev, input int eb);
      chk({tag, ".x"}, int'(x_s), ex);
      chk({tag, ".y"}, int'(y_s), ey);
      chk({tag, ".valid"}, int'(v_s), ev);
      chk({tag, ".busy"}, int'(busy_s), eb);
   endtask

   task automatic chk_wr_s(input string tag, input int wx, input int wy, input int c);
      chk({tag, ".wr_x"}, int'(wx_s), wx);
      chk({tag, ".wr_y"}, int'(wy_s), wy);
      chk({tag, ".color"}, int'(c_s), c);
   endtask

   localparam logic [3:0] B_NONE = 4'b0000;
   localparam logic [3:0] B_R    = 4'b0001;
   localparam logic [3:0] B_L    = 4'b0010;
   localparam logic [3:0] B_D    = 4'b0100;
   localparam logic [3:0] B_U    = 4'b1000;

   initial begin
      rst_m = 1'b0; step_m = 1'b0; btn_m = B_NONE; clear_m = 1'b0; rdy_m = 1'b1;
      rst_s = 1'b0; step_s = 1'b0; btn_s = B_NONE; clear_s = 1'b0; rdy_s = 1'b1;

      // Moves, cancellation, diagonal, backpressure on the full-size screen
      tbl.push_back(mk(1, B_R,       1, 121, 160, 1, 121, 160, 1));
      tbl.push_back(mk(0, B_NONE,    1, 121, 160, 0, 0, 0, 0));
      tbl.push_back(mk(0, B_NONE,    1, 121, 160, 0, 0, 0, 0));
      tbl.push_back(mk(0, B_NONE,    1, 121, 160, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_R,       1, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(0, B_NONE,    1, 122, 160, 0, 0, 0, 0));
      tbl.push_back(mk(0, B_NONE,    1, 122, 160, 0, 0, 0, 0));
      tbl.push_back(mk(0, B_NONE,    1, 122, 160, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_R,       1, 123, 160, 1, 123, 160, 1));
      tbl.push_back(mk(0, B_NONE,    1, 123, 160, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_U | B_L, 1, 122, 159, 1, 122, 159, 1));
      tbl.push_back(mk(0, B_NONE,    1, 122, 159, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_L | B_R, 1, 122, 159, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_U | B_D, 1, 122, 159, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'b1111,   1, 122, 159, 0, 0, 0, 0));
      tbl.push_back(mk(1, B_D,       0, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(1, B_R,       0, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(0, B_NONE,    0, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(1, B_U,       0, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(0, B_NONE,    0, 122, 160, 1, 122, 160, 1));
      tbl.push_back(mk(0, B_NONE,    1, 122, 160, 0, 0, 0, 0));
      tbl.push_back(mk(0, B_NONE,    1, 122, 160, 0, 0, 0, 0));

      repeat (2) @(negedge clk);
      rst_m = 1'b1;
      rst_s = 1'b1;

      chk("rst.x", int'(x_m), 120);
      chk("rst.y", int'(y_m), 160);
      chk("rst.valid", int'(v_m), 0);
      chk("rst.busy", int'(busy_m), 0);
      chk("rst.wr", int'({wx_m, wy_m, c_m}), 0);
      chk_s("rst_s", 2, 1, 0, 0);
      chk_wr_s("rst_s", 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step_m = tbl[i].stp;
         btn_m  = tbl[i].btn;
         rdy_m  = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("row%0d.x", i), int'(x_m), tbl[i].ex);
         chk($sformatf("row%0d.y", i), int'(y_m), tbl[i].ey);
         chk($sformatf("row%0d.valid", i), int'(v_m), tbl[i].ev);
         if (tbl[i].ev != 0) begin
            chk($sformatf("row%0d.wr_x", i), int'(wx_m), tbl[i].ewx);
            chk($sformatf("row%0d.wr_y", i), int'(wy_m), tbl[i].ewy);
            chk($sformatf("row%0d.color", i), int'(c_m), tbl[i].ec);
         end
      end
      chk("writes_after_table", hs_cnt, 5);

      // Walk to the left edge, then try to push past it
      for (int i = 0; i < 122; i++) begin
         step_m = 1'b1; btn_m = B_L; rdy_m = 1'b1;
         @(negedge clk);
         step_m = 1'b0;
         @(negedge clk);
      end
      chk("edge.x", int'(x_m), 0);
      chk("edge.y", int'(y_m), 160);
      step_m = 1'b1; btn_m = B_L;
      @(negedge clk);
      chk("clamp_left.valid", int'(v_m), 0);
      chk("clamp_left.x", int'(x_m), 0);
      btn_m = B_L | B_R;
      @(negedge clk);
      chk("clamp_lr.valid", int'(v_m), 0);
      btn_m = B_U | B_D | B_L;
      @(negedge clk);
      chk("clamp_udl.valid", int'(v_m), 0);
      chk("clamp_udl.pos", int'({x_m, y_m}), int'({9'd0, 9'd160}));
      step_m = 1'b0;
      @(negedge clk);
      chk("writes_after_clamp", hs_cnt, 127);

      // Asynchronous reset while a write is stalled
      step_m = 1'b1; btn_m = B_R; rdy_m = 1'b0;
      @(negedge clk);
      step_m = 1'b0;
      chk("pre_rst.valid", int'(v_m), 1);
      #2 rst_m = 1'b0;
      #1;
      chk("async_rst.x", int'(x_m), 120);
      chk("async_rst.y", int'(y_m), 160);
      chk("async_rst.valid", int'(v_m), 0);
      chk("async_rst.busy", int'(busy_m), 0);
      @(negedge clk);
      rst_m = 1'b1; rdy_m = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst.valid", int'(v_m), 0);

      // Small screen: clamp at the right and bottom edges, return to (2,1)
      drive_s(1, B_R, 1, 0);       chk_s("s_r1", 3, 1, 1, 0); chk_wr_s("s_r1", 3, 1, 1);
      drive_s(0, B_NONE, 1, 0);    chk_s("s_r1h", 3, 1, 0, 0);
      drive_s(1, B_R, 1, 0);       chk_s("s_rclamp", 3, 1, 0, 0);
      drive_s(1, B_D, 1, 0);       chk_s("s_d1", 3, 2, 1, 0);
      drive_s(0, B_NONE, 1, 0);    chk_s("s_d1h", 3, 2, 0, 0);
      drive_s(1, B_D, 1, 0);       chk_s("s_dclamp", 3, 2, 0, 0);
      drive_s(1, B_U | B_L, 1, 0); chk_s("s_ul", 2, 1, 1, 0);
      drive_s(0, B_NONE, 1, 0);    chk_s("s_ulh", 2, 1, 0, 0);

      // Full sweep with a stall, a stray step and a re-edge of clear inside it
      drive_s(0, B_NONE, 1, 1);
      for (int k = 0; k < 12; k++) begin
         chk_wr_s($sformatf("sweep%0d", k), k % 4, k / 4, 0);
         chk_s($sformatf("sweep%0d", k), 2, 1, 1, 1);
         if (k == 5) begin
            rdy_s = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk_wr_s("stall", 1, 1, 0);
               chk("stall.valid", int'(v_s), 1);
            end
            rdy_s = 1'b1;
         end
         step_s  = (k == 3);
         btn_s   = B_R;
         clear_s = (k != 7);
         @(negedge clk);
      end
      step_s = 1'b0;
      chk_s("cursor_redraw", 2, 1, 1, 0);
      chk_wr_s("cursor_redraw", 2, 1, 1);
      drive_s(0, B_NONE, 1, 1);
      chk_s("after_sweep", 2, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive_s(0, B_NONE, 1, 1);
         chk($sformatf("held_clear%0d.valid", i), int'(v_s), 0);
         chk($sformatf("held_clear%0d.busy", i), int'(busy_s), 0);
      end

      // Clear edge and step together, then reset at sweep pixel 5
      drive_s(0, B_NONE, 1, 0);
      drive_s(1, B_R, 1, 1);
      chk_s("clr_step", 2, 1, 1, 1);
      chk_wr_s("clr_step", 0, 0, 0);
      repeat (5) drive_s(0, B_NONE, 1, 1);
      chk_wr_s("pix5", 1, 1, 0);
      #2 rst_s = 1'b0;
      #1;
      chk_s("sweep_rst", 2, 1, 0, 0);
      step_s = 1'b0; clear_s = 1'b0;
      @(negedge clk);
      rst_s = 1'b1;
      drive_s(0, B_NONE, 1, 0);
      drive_s(0, B_NONE, 1, 0);
      chk_s("sweep_rst_idle", 2, 1, 0, 0);

      // Clear edge while an ink write is stalled is deferred until IDLE
      drive_s(1, B_R, 0, 0);    chk_s("pend_a", 3, 1, 1, 0);
      drive_s(0, B_NONE, 0, 1); chk_s("pend_b", 3, 1, 1, 0); chk_wr_s("pend_b", 3, 1, 1);
      drive_s(0, B_NONE, 1, 1); chk_s("pend_c", 3, 1, 0, 0);
      drive_s(0, B_NONE, 1, 1); chk_s("pend_d", 3, 1, 1, 1); chk_wr_s("pend_d", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
